// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, issue FSM encoding and the command record.
// No logic and no latency; the command record is 37 bits wide.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b1111;

  localparam int CMD_W = 37;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] opx;
    logic [15:0] opy;
    logic        cin;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO: a push is visible at the head one cycle later; push is dropped when full.
// The caller sees backpressure through full; pop is ignored when empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign fill    = count;
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;
  assign pop_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Buffers ALU commands, drives each onto alu_top for ALU_LAT/MUL_LAT cycles, returns ar/mult/sta.
// Idle-to-result latency LAT+1 cycles; cmd_ready = !full, result held until res_ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter int          ALU_LAT    = 2,
  parameter int          MUL_LAT    = 18,
  parameter logic [3:0]  MUL_OPCODE = OP_MUL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_opcode,
  input  logic [15:0]            cmd_opx,
  input  logic [15:0]            cmd_opy,
  input  logic                   cmd_cin,
  output logic [3:0]             alu_opcode,
  output logic [15:0]            alu_opx,
  output logic [15:0]            alu_opy,
  output logic                   alu_cin,
  input  logic [15:0]            alu_ar,
  input  logic [31:0]            alu_mult,
  input  logic [3:0]             alu_sta,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [15:0]            res_ar,
  output logic [31:0]            res_mult,
  output logic [3:0]             res_sta,
  output logic [3:0]             res_opcode,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   busy
);

  localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ALU = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_LAT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  cmd_t             push_dat;
  cmd_t             pop_dat;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             capture;

  assign push_dat  = '{opcode: cmd_opcode, opx: cmd_opx, opy: cmd_opy, cin: cmd_cin};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_DONE);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (cmd_valid),
    .push_dat (push_dat),
    .pop_vld  (pop),
    .pop_dat  (pop_dat),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .fill     (fill)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          cnt_nxt   = (pop_dat.opcode == MUL_OPCODE) ? CNT_MUL : CNT_ALU;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operands stay on the bus after capture; only the opcode drops to NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_opcode <= '0;
      alu_opx    <= '0;
      alu_opy    <= '0;
      alu_cin    <= 1'b0;
      res_ar     <= '0;
      res_mult   <= '0;
      res_sta    <= '0;
      res_opcode <= '0;
    end else begin
      if (pop) begin
        alu_opcode <= pop_dat.opcode;
        alu_opx    <= pop_dat.opx;
        alu_opy    <= pop_dat.opy;
        alu_cin    <= pop_dat.cin;
      end else if (capture) begin
        alu_opcode <= OP_NOP;
      end
      if (capture) begin
        res_ar     <= alu_ar;
        res_mult   <= alu_mult;
        res_sta    <= alu_sta;
        res_opcode <= alu_opcode;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-issue front end for `alu_top`. It accepts ALU commands (opcode, opx, opy, cin) over a valid/ready handshake and buffers them in a small FIFO. Each command is driven onto the ALU's operand ports for a fixed, opcode-dependent settle time; the block then captures `ar`, `mult_out` and `sta` and returns them over a valid/ready result handshake. It sits directly upstream of `alu_top` and owns that block's opcode/operand inputs.

## Interface
- `DEPTH`, 4: command FIFO entries, power of two, ≥2.
- `ALU_LAT`, 2: cycles from driving ALU inputs to capture, non-multiply opcodes; ≥1.
- `MUL_LAT`, 18: the same, for the multiply opcode; ≥1.
- `MUL_OPCODE`, 4'b1111: opcode that selects `MUL_LAT`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_opcode`  in  4  ALU opcode.
- `cmd_opx`  in  16  operand x.
- `cmd_opy`  in  16  operand y.
- `cmd_cin`  in  1  carry in.
- `alu_opcode`  out  4  to `alu_top.opcode`.
- `alu_opx`  out  16  to `alu_top.opx`.
- `alu_opy`  out  16  to `alu_top.opy`.
- `alu_cin`  out  1  to `alu_top.cin`.
- `alu_ar`  in  16  from `alu_top.ar`.
- `alu_mult`  in  32  from `alu_top.mult_out`.
- `alu_sta`  in  4  from `alu_top.sta`.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer takes result.
- `res_ar`  out  16  captured ar.
- `res_mult`  out  32  captured mult_out.
- `res_sta`  out  4  captured sta.
- `res_opcode`  out  4  opcode that produced the result.
- `fill`  out  log2(DEPTH)+1  FIFO occupancy.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FIFO:
  - Push on `cmd_valid && cmd_ready`.
  - Pop only by the FSM in IDLE when not empty.
  - Push and pop in the same cycle leave `fill` unchanged.
  - Pointers wrap modulo DEPTH; `fill` ranges from 0 to DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE, FIFO non-empty:
  - Pop the head entry.
  - Register its fields onto the `alu_*` outputs.
  - Load `cnt` with (opcode==MUL_OPCODE ? MUL_LAT : ALU_LAT) − 1.
  - Go to WAIT.
- WAIT:
  - `alu_*` outputs are held stable.
  - If `cnt`≠0, decrement it.
  - If `cnt`==0:
    - Capture `alu_ar`, `alu_mult` and `alu_sta` into the `res_*` registers, and the current opcode into `res_opcode`.
    - Set `res_valid`.
    - Drive `alu_opcode` to 4'b0000 (NOP); `alu_opx`/`alu_opy`/`alu_cin` keep their last values.
    - Go to DONE.
- DONE:
  - Hold `res_*` stable while `res_valid && !res_ready`.
  - On `res_ready`: clear `res_valid` and go to IDLE.
  - IDLE may pop on the next cycle, giving one bubble cycle per command.
- Opcode 4'b0000 is processed like any other command (ALU_LAT) and yields a result.
- `busy` = (state≠IDLE).

## Timing
- Reset value of every output is zero, except `cmd_ready`=1. Zero outputs: `alu_*`, `res_*`, `res_valid`, `fill`, `busy`.
- Reset clears the FIFO and the FSM state asynchronously. Reset during WAIT or DONE discards the in-flight command and its result.
- Latency into an idle, empty block, from the accept edge E0:
  - FIFO write at E0.
  - Pop and `alu_*` driven at E1.
  - `res_valid` high after E1+LAT.
  - Total: LAT+1 cycles (3 for ALU_LAT=2).
- Throughput with `res_ready` held high: one result every LAT+2 cycles.
- When full, `cmd_ready` is 0; an offered command is not taken and must be held by the producer.
- `res_*` change only at the WAIT→DONE transition.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants OP_NOP=4'b0000 … OP_MUL=4'b1111, also used by `alu_top`.
  - FSM state encoding.
  - Command struct width (37 bits: opcode, opx, opy, cin).
- Sub-module `alu_cmd_fifo`: parameterised synchronous FIFO holding 37-bit entries, with `fill` output. The FSM and capture logic stay in the top module.

## Test plan
Bench uses a stub ALU with ar=opx+opy+cin, mult_out={opx,opy}, sta=opcode. Stub outputs become valid one cycle after the inputs change.
- Single command: opcode 0101, opx 16'h2813, opy 16'hE572, cin 0, `res_ready`=1 → `res_valid` 3 cycles after accept; ar 16'h0D85, mult 32'h2813E572, sta 4'h5; `alu_opcode` back to 0.
- Multiply latency: opcode 1111, opx 16'h0003, opy 16'h0004 → `res_valid` exactly 19 cycles after accept; `res_opcode`=4'hF.
- Backpressure and full: `res_ready`=0; push 6 commands back to back.
  - Required: `cmd_ready` drops once `fill` reaches 4; `res_*` stay stable.
  - After `res_ready`=1: all 5 accepted commands emerge in order; the 6th is taken only when space frees.
- Simultaneous push/pop: with `fill`=2, push on the cycle IDLE pops → `fill` stays 2, order preserved.
- Reset mid-WAIT: assert `rst`=0 during a multiply → all outputs 0 and `cmd_ready`=1 immediately; no result appears after release; the next command completes normally.
- Wrap-around: stream 10 commands with incrementing opx 0…9 through DEPTH=4 → results in order, ar=opx+opy each.
